peripheral_uart_rfifo_gen_wb: RTL and testbench

Parametrised UART receive FIFO for the WishBone UART peripheral, sitting between the receiver shift logic and the register file (RBR/LSR/IIR). Stores one received character plus its per-character error flags (break/framing/parity) per entry. Adds over the fixed 16-entry FIFO:
- configurable width and depth
- first-word-fall-through output
- full/empty flags
- a programmable interrupt trigger level
- a live count of errored entries
- an optional character-timeout detector

---
 rtl/peripheral_uart_rfifo_gen_wb.sv | 151 +++++++++++++++
 tb/tb_peripheral_uart_rfifo_gen_wb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_uart_rfifo_gen_wb.sv
// UART receive FIFO: {char, error flags} entries, first-word-fall-through head, error tracking, trigger level.
// Optional character-timeout detector is enabled by defining PERIPHERAL_UART_RFIFO_TIMEOUT_EN.
module peripheral_uart_rfifo_gen_wb #(
  parameter int DATA_WIDTH    = 8,
  parameter int FLAG_WIDTH    = 3,
  parameter int DEPTH         = 16,
  parameter int PTR_W         = $clog2(DEPTH),
  parameter int CNT_W         = PTR_W + 1,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                             clk,
  input  logic                             wb_rst_ni,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_WIDTH+FLAG_WIDTH-1:0] data_in,
  input  logic                             fifo_reset,
  input  logic                             reset_status,
  input  logic [1:0]                       trig_level,
  input  logic                             char_tick,
  output logic [DATA_WIDTH+FLAG_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]                 count,
  output logic                             empty,
  output logic                             full,
  output logic                             overrun,
  output logic                             error_bit,
  output logic [CNT_W-1:0]                 error_count,
  output logic                             trigger,
  output logic                             timeout
);
  localparam int EW = DATA_WIDTH + FLAG_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LVL_1    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LVL_Q    = CNT_W'(DEPTH / 4);
  localparam logic [CNT_W-1:0] LVL_H    = CNT_W'(DEPTH / 2);
  localparam logic [CNT_W-1:0] LVL_F    = CNT_W'(DEPTH - 2);

  // push/pop are single-cycle strobes with no back-pressure: a push while full
  // is dropped (overrun), a pop while empty is ignored; pop consumes data_out.
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d, bottom_q, bottom_d;
  logic [CNT_W-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
  logic             overrun_q, overrun_d;
  logic             do_push, do_pop, wr_en, err_in, err_out;
  logic [EW-1:0]    head;
  logic [CNT_W-1:0] level;

  always_comb begin
    head      = mem_q[bottom_q];
    do_pop    = pop && (count_q != '0);
    do_push   = push && ((count_q != FULL_CNT) || do_pop);
    err_in    = do_push && (data_in[FLAG_WIDTH-1:0] != '0);
    err_out   = do_pop && (head[FLAG_WIDTH-1:0] != '0);
    wr_en     = do_push && !fifo_reset;
    top_d     = top_q;
    bottom_d  = bottom_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    overrun_d = overrun_q;
    if (fifo_reset) begin
      top_d     = '0;
      bottom_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (do_push) top_d = top_q + PTR_W'(1);
      if (do_pop)  bottom_d = bottom_q + PTR_W'(1);
      if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
      if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
      if (err_in && !err_out) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (err_out && !err_in) err_cnt_d = err_cnt_q - CNT_W'(1);
      if (push && !do_push) overrun_d = 1'b1;
      // A status read in the same cycle as a new overrun still clears it.
      if (reset_status) overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      top_q     <= '0;
      bottom_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      top_q     <= top_d;
      bottom_q  <= bottom_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_ni && wr_en) mem_q[top_q] <= data_in;
  end

  always_comb begin
    case (trig_level)
      2'b00:   level = LVL_1;
      2'b01:   level = LVL_Q;
      2'b10:   level = LVL_H;
      default: level = LVL_F;
    endcase
  end

  assign data_out    = (count_q == '0) ? '0 : head;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign overrun     = overrun_q;
  assign error_count = err_cnt_q;
  assign error_bit   = (err_cnt_q != '0);
  assign trigger     = (count_q >= level);

`ifdef PERIPHERAL_UART_RFIFO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CHARS + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CHARS);
  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout_q, timeout_d;

  // Idle character times are only meaningful while data waits in the FIFO.
  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (fifo_reset || push || pop || (count_q == '0)) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (char_tick && (idle_q != TO_MAX)) idle_d = idle_q + TO_W'(1);
      timeout_d = (idle_q == TO_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!wb_rst_ni) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_tick;
  assign unused_tick = char_tick ^ (TIMEOUT_CHARS == 0);
  assign timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_peripheral_uart_rfifo_gen_wb.sv
// Bench for peripheral_uart_rfifo_gen_wb: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_peripheral_uart_rfifo_gen_wb;
  localparam int DEPTH = 16;
  localparam int TC    = 4;
  localparam int EW    = 11;
`ifdef PERIPHERAL_UART_RFIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          wb_rst_ni = 1'b0;
  logic          push = 1'b0, pop = 1'b0, fifo_reset = 1'b0, reset_status = 1'b0, char_tick = 1'b0;
  logic [EW-1:0] data_in = '0;
  logic [1:0]    trig_level = 2'b00;
  logic [EW-1:0] data_out;
  logic [4:0]    count, error_count;
  logic          empty, full, overrun, error_bit, trigger, timeout;

  peripheral_uart_rfifo_gen_wb dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .push(push), .pop(pop), .data_in(data_in),
    .fifo_reset(fifo_reset), .reset_status(reset_status), .trig_level(trig_level),
    .char_tick(char_tick), .data_out(data_out), .count(count), .empty(empty), .full(full),
    .overrun(overrun), .error_bit(error_bit), .error_count(error_count), .trigger(trigger),
    .timeout(timeout)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: contents as a queue, derived quantities computed from it
  logic [EW-1:0] exp_q[$];
  bit            m_overrun = 1'b0;
  bit            m_timeout = 1'b0;
  int            m_idle    = 0;
  bit            model_live = 1'b0;

  function automatic int level_of(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return DEPTH / 4;
      2'b10:   return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic int errs_held();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][2:0] != 3'b000) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    if (!wb_rst_ni || fifo_reset) begin
      exp_q.delete();
      m_overrun = 1'b0;
      m_idle    = 0;
      m_timeout = 1'b0;
    end else begin
      if (push || pop || exp_q.size() == 0) begin
        m_idle    = 0;
        m_timeout = 1'b0;
      end else begin
        m_timeout = TO_EN && (m_idle == TC);
        if (char_tick && m_idle < TC) m_idle++;
      end
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(data_in);
        else m_overrun = 1'b1;
      end
      if (reset_status) m_overrun = 1'b0;
    end
    model_live = 1'b1;
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      check("cmp_data_out", 32'(data_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
      check("cmp_count", 32'(count), 32'(exp_q.size()));
      check("cmp_empty", 32'(empty), 32'(exp_q.size() == 0));
      check("cmp_full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("cmp_overrun", 32'(overrun), 32'(m_overrun));
      check("cmp_error_count", 32'(error_count), 32'(errs_held()));
      check("cmp_error_bit", 32'(error_bit), 32'(errs_held() != 0));
      check("cmp_trigger", 32'(trigger), 32'(exp_q.size() >= level_of(trig_level)));
      check("cmp_timeout", 32'(timeout), 32'(m_timeout));
    end
  end

  // driver tasks: each occupies one clock and returns 1 time unit after the edge
  task automatic drive(input logic p, input logic o, input logic [EW-1:0] d, input logic t);
    push = p; pop = o; data_in = d; char_tick = t;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; char_tick = 1'b0;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic flush();
    fifo_reset = 1'b1;
    @(posedge clk); #1;
    fifo_reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_error_bit"}, 32'(error_bit), 32'd0);
    check({tag, "_error_count"}, 32'(error_count), 32'd0);
    check({tag, "_trigger"}, 32'(trigger), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    wb_rst_ni = 1'b1;
    idle_cycle();

    // fill 0x41..0x50
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, {8'(8'h41 + i), 3'b000}, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_head", 32'(data_out), 32'h208);

    // overrun at full, then status clear
    drive(1'b1, 1'b0, {8'h99, 3'b000}, 1'b0);
    check("ovr_count", 32'(count), 32'd16);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_head", 32'(data_out), 32'h208);
    reset_status = 1'b1;
    @(posedge clk); #1;
    reset_status = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      check("drain_order", 32'(data_out), 32'({8'(8'h41 + i), 3'b000}));
      drive(1'b0, 1'b1, '0, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_data_zero", 32'(data_out), 32'd0);
    drive(1'b0, 1'b1, '0, 1'b0);
    check("pop_empty_count", 32'(count), 32'd0);

    // simultaneous push+pop on empty
    drive(1'b1, 1'b1, {8'h5A, 3'b001}, 1'b0);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_head", 32'(data_out), 32'h2D1);
    drive(1'b0, 1'b1, '0, 1'b0);

    // simultaneous push+pop at full
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, {8'(8'h60 + i), 3'b000}, 1'b0);
    drive(1'b1, 1'b1, {8'h77, 3'b000}, 1'b0);
    check("pp_full_count", 32'(count), 32'd16);
    check("pp_full_overrun", 32'(overrun), 32'd0);
    check("pp_full_head", 32'(data_out), 32'h308);
    flush();

    // error tracking
    drive(1'b1, 1'b0, {8'h10, 3'b010}, 1'b0);
    drive(1'b1, 1'b0, {8'h20, 3'b000}, 1'b0);
    drive(1'b1, 1'b0, {8'h30, 3'b100}, 1'b0);
    check("err_after_push", 32'(error_count), 32'd2);
    check("err_bit_set", 32'(error_bit), 32'd1);
    drive(1'b0, 1'b1, '0, 1'b0);
    check("err_pop1", 32'(error_count), 32'd1);
    drive(1'b0, 1'b1, '0, 1'b0);
    check("err_pop2", 32'(error_count), 32'd1);
    drive(1'b0, 1'b1, '0, 1'b0);
    check("err_pop3", 32'(error_count), 32'd0);
    check("err_bit_clear", 32'(error_bit), 32'd0);

    // trigger at half depth, then flush
    trig_level = 2'b10;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, {8'(8'h01 + i), 3'b000}, 1'b0);
    check("trig_7", 32'(trigger), 32'd0);
    drive(1'b1, 1'b0, {8'h08, 3'b000}, 1'b0);
    check("trig_8", 32'(trigger), 32'd1);
    flush();
    check("flush_count", 32'(count), 32'd0);
    check("flush_trigger", 32'(trigger), 32'd0);
    check("flush_data", 32'(data_out), 32'd0);

    // reset mid-burst
    trig_level = 2'b00;
    drive(1'b1, 1'b0, {8'hA1, 3'b001}, 1'b0);
    drive(1'b1, 1'b0, {8'hA2, 3'b010}, 1'b0);
    check("burst_trigger", 32'(trigger), 32'd1);
    wb_rst_ni = 1'b0;
    drive(1'b1, 1'b0, {8'hA3, 3'b100}, 1'b0);
    check_reset_values("midrst");
    wb_rst_ni = 1'b1;
    idle_cycle();

    // character timeout
    drive(1'b1, 1'b0, {8'hC3, 3'b000}, 1'b0);
    for (int i = 0; i < TC; i++) drive(1'b0, 1'b0, '0, 1'b1);
    idle_cycle();
    check("to_held", 32'(timeout), 32'(TO_EN));
    drive(1'b0, 1'b1, '0, 1'b0);
    check("to_after_pop", 32'(timeout), 32'd0);
    for (int i = 0; i < TC + 2; i++) drive(1'b0, 1'b0, '0, 1'b1);
    idle_cycle();
    check("to_empty", 32'(timeout), 32'd0);

    idle_cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
